// File: rtl/mult_ctrl_pkg.sv
// Shared control-state encoding for the signed add-shift multiplier.
// The datapath bench imports this package for its state-aware checks.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHIFT,
    HOLD
  } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer. It has a synchronous clear and
// an increment enable, and flags the final iteration.
module mult_iter_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q;

  always_ff @(posedge Clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the WIDTH-bit signed add-shift multiplier. It runs one clear
// cycle, then WIDTH add/sub-then-shift iterations, and holds until Run drops.
module mult_sequencer
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clr_XA,
  output logic          Ld_B,
  output logic          Add_En,
  output logic          Sub_En,
  output logic          Shift_En,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Iter
);

  mult_state_t state_q, state_d;
  logic        cnt_clr, cnt_inc, last;
  logic        clr_xa_raw, ld_b_raw;

  // Reset clears the counter alongside the state register.
  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter_counter (
    .Clk   (Clk),
    .clr   (cnt_clr | ~Reset),
    .inc   (cnt_inc),
    .count (Iter),
    .last  (last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    clr_xa_raw = 1'b0;
    ld_b_raw   = 1'b0;
    Add_En     = 1'b0;
    Sub_En     = 1'b0;
    Shift_En   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = CLR;
          cnt_clr = 1'b1;
        end else begin
          clr_xa_raw = ClearA_LoadB;
          ld_b_raw   = ClearA_LoadB;
        end
      end
      CLR: begin
        clr_xa_raw = 1'b1;
        Busy       = 1'b1;
        state_d    = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // The final partial product carries the sign bit's negative weight.
        if (M) begin
          Add_En = ~last;
          Sub_En = last;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (last) begin
          cnt_clr = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_inc = 1'b1;
          state_d = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Keep the front-end load path quiet while reset is asserted.
  assign Clr_XA = clr_xa_raw & Reset;
  assign Ld_B   = ld_b_raw & Reset;

endmodule
